// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// UpDownModCounter -- modulo-N up/down counter digit with parallel load.
//
// One digit counts 0..N-1 up or down. Several digits chain into a multi-digit
// counter by wiring each digit's tc to the next digit's en. Every digit shares
// clk and dir. No extra glue logic is needed.
//
// Parameters:
//   N     modulus, integer >= 2
//   K     count width, must satisfy 2**K >= N
//
// Ports:
//   clk    in   rising-edge clock for all state
//   rst    in   asynchronous active-high reset (count=0, wrap=0)
//   en     in   count enable / cascade input from a lower digit's tc
//   dir    in   1 = count up, 0 = count down
//   load   in   synchronous parallel load strobe (wins over en)
//   din    in   parallel load value, clamped to N-1 if out of range
//   count  out  registered count, always within 0..N-1
//   tc     out  combinational terminal count, feeds the next digit's en
//   wrap   out  registered one-cycle pulse after a completed wrap
// ---------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int N = 10,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [K-1:0] din,
  output logic [K-1:0] count,
  output logic         tc,
  output logic         wrap
);

  // Refuse to build a counter whose code space cannot hold every value.
  generate
    if (N < 2 || (2 ** K) < N) begin : gBadParams
      $error("updown_mod_counter: need N >= 2 and 2**K >= N");
    end
  endgenerate

  localparam logic [K-1:0] MaxVal = K'(N - 1);

  logic [K-1:0] count_q, count_d;
  logic         wrap_q, wrap_d;

  // tc is the cascade carry/borrow. It is suppressed during a load so that a
  // loading digit never ripples into the next digit.
  assign tc = en & ~load & ((dir & (count_q == MaxVal)) | (~dir & (count_q == '0)));

  // Next-state logic with priority load, then en, then hold. The count is
  // compared against the end value before each step. This keeps it inside
  // 0..N-1 even when N is not a power of two.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (din > MaxVal) ? MaxVal : din;
    end else if (en) begin
      wrap_d = tc;
      if (dir) begin
        count_d = (count_q == MaxVal) ? '0 : count_q + K'(1);
      end else begin
        count_d = (count_q == '0) ? MaxVal : count_q - K'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 The block SHALL have parameter N, default 10: modulus, integer >= 2.
REQ-002 The block SHALL have parameter K, default 4: count width; 2^K >= N is required, and elaboration SHALL fail otherwise.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable; also serves as the cascade input from the tc of a lower digit.
REQ-006 dir  input  1  direction: 1 = up (increment), 0 = down (decrement).
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 din  input  K  parallel load value.
REQ-009 count  output  K  registered current value, always in range 0..N-1.
REQ-010 tc  output  1  combinational terminal count; cascades into the en of the next digit.
REQ-011 wrap  output  1  registered one-cycle pulse marking a completed wrap.

Function
REQ-012 All state SHALL change only on the rising edge of clk, except on rst assertion.
REQ-013 Per-edge priority SHALL be: load, then en, then hold.
REQ-014 load=1 with din <= N-1 SHALL set count to din on the next edge; en and dir are ignored on that edge.
REQ-015 load=1 with din >= N SHALL set count to N-1 (clamp); count SHALL never leave 0..N-1.
REQ-016 A load SHALL never assert wrap on the following cycle.
REQ-017 load=0, en=1, dir=1 SHALL increment count: 0, 1, ..., N-1, then 0 (wrap up).
REQ-018 load=0, en=1, dir=0 SHALL decrement count: N-1, ..., 1, 0, then N-1 (wrap down).
REQ-019 load=0, en=0 SHALL hold count unchanged, including when dir changes.
REQ-020 tc SHALL equal en & ~load & ((dir & count==N-1) | (~dir & count==0)), evaluated combinationally with zero latency.
REQ-021 wrap SHALL be 1 for exactly the cycle after an edge on which tc was 1, and 0 otherwise.
REQ-022 A dir change SHALL take effect on the same edge it is sampled; there is no pipeline delay.
REQ-023 Arithmetic SHALL be modulo N, computed in K bits, with no overflow into unused codes.
REQ-024 Behavior for N = 2 SHALL be a toggle between 0 and 1 in either direction, with tc per REQ-020.
REQ-025 Cascading SHALL work by connecting digit i tc to digit i+1 en with a shared dir and clk, forming a multi-digit modulo-N^m up/down counter; the block SHALL need no extra logic for this.

Reset
REQ-026 rst=1 SHALL immediately force count=0 and wrap=0, independent of clk.
REQ-027 While rst=1, tc SHALL still follow REQ-020 from count=0, so tc=1 if en=1, dir=0 and load=0.
REQ-028 Deasserting rst SHALL resume operation on the first clk rising edge at which rst=0.
REQ-029 rst asserted mid-count or during a load cycle SHALL discard the pending update, and count SHALL remain 0.

Verification
REQ-030 N=10: reset, then en=1, dir=1 for 12 clocks -> count 1..9, 0, 1, 2; tc=1 only while count=9; wrap=1 in the cycle count=0 first appears.
REQ-031 N=10: reset, then en=1, dir=0 -> count 9, 8, ...; tc=1 at count=0 before the first edge; wrap pulses with count=9.
REQ-032 N=10: load=1, din=7, en=1 -> count=7 and wrap=0; load=1, din=12 -> count=9 (clamp); load=1, din=15 -> count=9.
REQ-033 Two digits cascaded, N=10: up from 00 for 100 clocks -> reads 99 then 00; upper-digit wrap pulses once; switching dir=0 at 45 gives 44.
REQ-034 count=5, en=1, dir=1: assert rst between clock edges -> count=0 at once, no wrap; after release, first edge gives count=1.
REQ-035 en toggled 1/0 on alternate cycles with dir flipping -> count holds on every en=0 cycle and steps per dir on every en=1 cycle; count stays in range 0..9 throughout.
